// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and width helpers for the FIFO read arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Burst counter width: must hold the value MAX_BURST itself.
    function automatic int len_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Requester index width; never below one bit.
    function automatic int id_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Read-side handshake between the arbiter and the FIFO read interface block.
interface fifo_read_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_read_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    // Arbiter side: issues reads, observes empty flag and data.
    modport master (output fifo_read_en, input fifo_empty, input fifo_rdata);
    // FIFO side: consumes read strobe, supplies flag and data.
    modport slave  (input fifo_read_en, output fifo_empty, output fifo_rdata);
endinterface

// File: rtl/fifo_read_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_idx
);

    logic [ID_W-1:0] cand;
    logic            found;

    // Walk the requesters starting at ptr, wrapping at NUM_REQ (not 2**ID_W).
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = cand;
            end
            cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Burst read arbiter: grants one requester at a time a bounded run of FIFO reads.
module fifo_read_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int LEN_W     = len_w(MAX_BURST),
    localparam int ID_W      = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    fifo_read_arbiter_if.master      fr,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rvalid,
    output logic [ID_W-1:0]          rid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     busy
);

    // Address width belongs to the FIFO block; only sanity-checked here.
    if (NUM_REQ < 2 || NUM_REQ > 8 || ADDR_WIDTH < 1) begin : g_bad_param
        $error("fifo_read_arbiter: illegal parameter value");
    end

    arb_state_t         state;
    logic [LEN_W-1:0]   cnt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    owner;
    logic [NUM_REQ-1:0] pick;
    logic [ID_W-1:0]    pick_idx;
    logic [LEN_W-1:0]   len_arr [NUM_REQ];
    logic [LEN_W-1:0]   sel_len;
    logic [LEN_W-1:0]   load_len;
    logic               read_en;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign len_arr[i] = req_len[i*LEN_W +: LEN_W];
    end

    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req      (req),
        .ptr      (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // Clamp the winner's length into 1..MAX_BURST.
    always_comb begin
        sel_len  = len_arr[pick_idx];
        load_len = sel_len;
        if (sel_len == '0)
            load_len = LEN_W'(1);
        else if (sel_len > LEN_W'(MAX_BURST))
            load_len = LEN_W'(MAX_BURST);
    end

    // Read only while bursting, data available, and the owner still wants it.
    assign read_en         = (state == BURST) && !fr.fifo_empty && req[owner];
    assign fr.fifo_read_en = read_en;
    assign rdata           = fr.fifo_rdata;
    assign busy            = (state != IDLE);

    // Arbitration FSM; gnt drops as soon as the burst ends so it is zero outside BURST.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
            owner  <= '0;
            rvalid <= 1'b0;
            rid    <= '0;
        end else begin
            rvalid <= read_en;
            rid    <= owner;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= pick;
                        owner <= pick_idx;
                        cnt   <= load_len;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        gnt   <= '0;
                        state <= DONE;
                    end else if (read_en) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            gnt   <= '0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    gnt    <= '0;
                    cnt    <= '0;
                    rr_ptr <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: transaction-level model plus directed scenarios.
module tb_fifo_read_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;
    localparam int LW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]   gnt;
    logic            rvalid;
    logic [1:0]      rid;
    logic [7:0]      rdata;
    logic            busy;

    fifo_read_arbiter_if #(.DATA_WIDTH(8)) fif ();

    fifo_read_arbiter #(
        .DATA_WIDTH(8), .ADDR_WIDTH(5), .NUM_REQ(NR), .MAX_BURST(MB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .fr      (fif.master),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rid     (rid),
        .rdata   (rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 = waiting, 1 = owner holds a burst, 2 = wrap-up cycle.
    int m_phase = 0, m_owner = 0, m_ptr = 0, m_left = 0;
    int m_rvalid = 0, m_rid = 0;
    bit started = 0;

    // Observations accumulated by the compare loop.
    int cyc = 0, n_reads = 0, n_rv = 0;
    int g_id[$];
    int g_cyc[$];
    logic [NR-1:0] prev_gnt = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_rd();
        return (m_phase == 1 && !fif.fifo_empty && req[m_owner]) ? 1 : 0;
    endfunction

    function automatic int m_gnt();
        return (m_phase == 1) ? (1 << m_owner) : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        fif.fifo_rdata = fif.fifo_rdata + 8'h13;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_gnt_clear(input int budget);
        int n;
        n = 0;
        while (gnt != '0 && n < budget) begin
            tick();
            n++;
        end
        chk("burst_ends", int'(gnt == '0), 1);
    endtask

    // Model advance: what the spec says must happen at each rising edge.
    task automatic model_step();
        int rd, c, l;
        rd = m_rd();
        if (rst) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_left = 0;
            m_rvalid = 0; m_rid = 0;
        end else begin
            m_rvalid = rd;
            m_rid    = m_owner;
            case (m_phase)
                0: if (req != '0) begin
                    for (int k = 0; k < NR; k++) begin
                        c = (m_ptr + k) % NR;
                        if (req[c]) begin
                            m_owner = c;
                            break;
                        end
                    end
                    l = int'(req_len[m_owner*LW +: LW]);
                    m_left  = (l == 0) ? 1 : ((l > MB) ? MB : l);
                    m_phase = 1;
                end
                1: if (!req[m_owner]) m_phase = 2;
                   else if (rd == 1) begin
                       m_left--;
                       if (m_left == 0) m_phase = 2;
                   end
                default: begin
                    m_ptr   = (m_owner + 1) % NR;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    task automatic compare_step();
        cyc++;
        chk("gnt", int'(gnt), m_gnt());
        chk("read_en", int'(fif.fifo_read_en), m_rd());
        chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
        chk("rvalid", int'(rvalid), m_rvalid);
        chk("rid", int'(rid), m_rid);
        chk("rdata", int'(rdata), int'(fif.fifo_rdata));
        if (fif.fifo_read_en) n_reads++;
        if (rvalid) n_rv++;
        if (gnt != '0 && prev_gnt == '0) begin
            g_id.push_back($clog2(gnt));
            g_cyc.push_back(cyc);
        end
        prev_gnt = gnt;
    endtask

    initial begin
        int r0, v0, g0;
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};

        rst = 1'b1; req = '0; req_len = '0;
        fif.fifo_empty = 1'b0; fif.fifo_rdata = 8'h5a;

        fork
            forever begin
                @(posedge clk);
                model_step();
                started = 1;
            end
            forever begin
                @(negedge clk);
                if (started) compare_step();
            end
        join_none

        // Reset state
        ticks(2);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rvalid", int'(rvalid), 0);
        chk("rst_rid", int'(rid), 0);
        chk("rst_read_en", int'(fif.fifo_read_en), 0);
        rst = 1'b0;

        // Single requester, len 3
        r0 = n_reads; v0 = n_rv;
        req = 4'b0001; req_len = {3'd0, 3'd0, 3'd0, 3'd3};
        tick();
        chk("s1_gnt_c1", int'(gnt), 1);
        chk("s1_rd_c1", int'(fif.fifo_read_en), 1);
        tick();
        chk("s1_rvalid_c2", int'(rvalid), 1);
        chk("s1_rid_c2", int'(rid), 0);
        wait_gnt_clear(10);
        chk("s1_done_busy", int'(busy), 1);
        req = '0;
        ticks(2);
        chk("s1_idle", int'(busy), 0);
        chk("s1_reads", n_reads - r0, 3);
        chk("s1_rvalids", n_rv - v0, 3);

        // Fairness: all four, len 1 each, from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0;
        g0 = g_id.size();
        req = 4'b1111; req_len = {4{3'd1}};
        ticks(14);
        req = '0;
        ticks(3);
        chk("rr_grants", g_id.size() - g0, 5);
        if (g_id.size() - g0 == 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", g_id[g0+i], exp_ord[i]);
            for (int i = 0; i < 4; i++) chk("rr_gap", g_cyc[g0+i+1] - g_cyc[g0+i], 3);
        end

        // Empty stall: requester 1, len 4, FIFO empty for 3 cycles after read 2
        r0 = n_reads; v0 = n_rv;
        req = 4'b0010; req_len = {3'd0, 3'd0, 3'd4, 3'd0};
        ticks(3);
        fif.fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rd", int'(fif.fifo_read_en), 0);
            chk("stall_gnt", int'(gnt), 2);
            tick();
        end
        fif.fifo_empty = 1'b0;
        #1;
        chk("stall_resume", int'(fif.fifo_read_en), 1);
        wait_gnt_clear(10);
        req = '0;
        ticks(2);
        chk("stall_reads", n_reads - r0, 4);
        chk("stall_rvalids", n_rv - v0, 4);

        // Early drop: requester 2, len 4, request removed after 2 reads
        r0 = n_reads;
        req = 4'b0100; req_len = {3'd0, 3'd4, 3'd0, 3'd0};
        ticks(3);
        req = '0;
        #1;
        chk("drop_rd", int'(fif.fifo_read_en), 0);
        tick();
        chk("drop_done_gnt", int'(gnt), 0);
        chk("drop_done_busy", int'(busy), 1);
        tick();
        chk("drop_idle", int'(busy), 0);
        chk("drop_reads", n_reads - r0, 2);

        // Pointer now 3: requester 3 beats 0; its len 0 clamps to 1
        r0 = n_reads;
        req = 4'b1001; req_len = {3'd0, 3'd0, 3'd0, 3'd3};
        tick();
        chk("ptr_after_drop", int'(gnt), 8);
        wait_gnt_clear(10);
        req = '0;
        ticks(2);
        chk("clamp0_reads", n_reads - r0, 1);

        // Length 7 clamps to MAX_BURST
        r0 = n_reads;
        req = 4'b0001; req_len = {3'd0, 3'd0, 3'd0, 3'd7};
        tick();
        chk("clamp7_gnt", int'(gnt), 1);
        wait_gnt_clear(10);
        req = '0;
        ticks(2);
        chk("clamp7_reads", n_reads - r0, 4);

        // Reset after first read of a len-4 burst
        req = 4'b0010; req_len = {3'd0, 3'd0, 3'd4, 3'd0};
        tick();
        chk("mid_rd", int'(fif.fifo_read_en), 1);
        rst = 1'b1;
        tick();
        chk("mid_gnt", int'(gnt), 0);
        chk("mid_rvalid", int'(rvalid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_rid", int'(rid), 0);
        chk("mid_rd_off", int'(fif.fifo_read_en), 0);
        rst = 1'b0;
        req = 4'b1111; req_len = {4{3'd1}};
        tick();
        chk("mid_ptr0", int'(gnt), 1);
        req = '0;
        wait_gnt_clear(10);
        ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
